prng_matvec_iter: RTL and testbench
===================================

# prng_matvec_iter

Iteration sequencer for the chaotic PRNG core, directly downstream of the parameter memory. It latches the 3x3 coupling matrix A and the seed vector x (IEEE-754 single precision). It then repeatedly computes y = A·x by time-multiplexing one external FP multiplier and one external FP adder over request/done handshakes. Each result vector is presented on a valid/ready output, and y is fed back as the next x.

## Interface
Parameters:
- PRECISION, 32, operand/result word width (IEEE-754 single; only 32 supported)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; honoured only in IDLE; latches A and seed, begins iteration
- run  in  1  sampled at output acceptance: 1 = continue with next iteration, 0 = return to IDLE
- A00..A22  in  PRECISION each  matrix coefficients (row, col)
- x0_init, x1_init, x2_init  in  PRECISION each  seed vector
- mul_req  out  1  multiplier request, level-held until mul_done
- mul_op_a, mul_op_b  out  PRECISION each  multiplier operands (A_ij, x_j)
- mul_done  in  1  multiplier result valid, one-cycle pulse
- mul_res  in  PRECISION  product
- add_req  out  1  adder request, level-held until add_done
- add_op_a, add_op_b  out  PRECISION each  adder operands (acc, product)
- add_done  in  1  adder result valid, one-cycle pulse
- add_res  in  PRECISION  sum
- y0, y1, y2  out  PRECISION each  result vector of current iteration
- out_valid  out  1  y0..y2 valid
- out_ready  in  1  consumer accepts y
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, MUL, ADD, OUT.
- IDLE: on start, register A and x_init into internal A/x registers. Set row i=0, col j=0, then go to MUL.
- MUL: assert mul_req with op_a=A_ij, op_b=x_j. On mul_done, capture product p.
  - If j==0: acc=p, then advance.
  - If j>0: go to ADD.
- ADD: assert add_req with op_a=acc, op_b=p. On add_done, acc=add_res, then advance.
- Advance step:
  - If j<2: j++, go to MUL.
  - Else: y_i=acc. If i<2: i++, j=0, go to MUL. Otherwise go to OUT.
- OUT: out_valid=1 and y held stable. On out_valid&&out_ready, x<=y and clear out_valid.
  - If run=1: i=j=0, go to MUL.
  - Otherwise go to IDLE, keeping x and y.
- Every iteration reads the latched A. Changes to A/x_init inputs have no effect until the next start.
- Operands stay stable while the corresponding req is high. mul_done/add_done are ignored when the matching req is low.
- Without skip, each iteration issues exactly 9 mul requests and 6 add requests. The arithmetic itself (rounding, NaN, denormals) is owned by the external units; this block passes bits unmodified.

## Timing
- Reset (async, rst_n=0): state=IDLE, i=j=0.
  - Outputs: mul_req=add_req=out_valid=busy=0; y0..y2=0; all operand outputs=0; internal A/x=0.
- Reset mid-iteration: abort immediately with no output. Pending done pulses after release are ignored.
- req rises the cycle after entering MUL/ADD. It falls the cycle after done is sampled.
- done may arrive in the first cycle req is high.
- The next request issues one cycle after the previous done.
- out_valid rises one cycle after the final add_done of row 2.
- start while busy is ignored.

## Configuration
- PRNG_ZERO_SKIP_EN defined: a coefficient A_ij whose bits[30:0]==0 (±0) is skipped, with no mul_req.
  - Skipped terms also need no add.
  - acc initialises from the first non-skipped product of the row.
  - A row that is entirely zero yields y_i=32'h00000000.
- PRNG_ZERO_SKIP_EN undefined: every term is multiplied and accumulated; counts are fixed at 9 mul / 6 add per iteration.

## Test plan
- Identity: A=I (diag 32'h3F800000, rest 0), x_init=(3F800000, 40000000, 40400000), behavioural FPU of latency 3, run=0.
  - Required: y=(3F800000, 40000000, 40400000) with one out_valid, then IDLE with busy=0.
- Default PRNG matrix: A01=A21=3F000000, A02=A20=3D4CCCCD, A10=A12=3EAAAAAB, other A entries 0, x=(3DCCCCCD, 3C23D70A, 0).
  - Required: y0≈0.005, y1≈0.0333, y2≈0.01, each within 1 ulp.
  - Skip disabled: 9 mul and 6 add requests counted.
  - With PRNG_ZERO_SKIP_EN: 6 mul and 3 add requests counted.
- Continuous mode: run=1, A=2·I (40000000 diagonal), x=(3F800000, 0, 0), out_ready always high.
  - Required: successive y0 = 40000000, 40800000, 41000000.
- Backpressure: hold out_ready=0 for 10 cycles in OUT.
  - Required: out_valid and y stay stable; no mul_req/add_req asserted; the next iteration starts only after acceptance.
- Reset mid-ADD of row 1: pulse rst_n low.
  - Required: all outputs 0 asynchronously; a late add_done is ignored; a new start restarts cleanly from row 0.
- Zero-latency FPU: done asserted in the same cycle as req.
  - Required: correct identity result; every operand pair observed exactly once.

Source files
------------

// File: rtl/prng_matvec_iter.sv
// prng_matvec_iter: iterates y = A*x over one shared external FP multiplier and adder,
// presenting each y on a valid/ready port and feeding it back as the next x.
// Optional build macro PRNG_ZERO_SKIP_EN: skip terms whose coefficient is +/-0.
module prng_matvec_iter #(
    parameter int PRECISION = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 run,
    input  logic [PRECISION-1:0] A00,
    input  logic [PRECISION-1:0] A01,
    input  logic [PRECISION-1:0] A02,
    input  logic [PRECISION-1:0] A10,
    input  logic [PRECISION-1:0] A11,
    input  logic [PRECISION-1:0] A12,
    input  logic [PRECISION-1:0] A20,
    input  logic [PRECISION-1:0] A21,
    input  logic [PRECISION-1:0] A22,
    input  logic [PRECISION-1:0] x0_init,
    input  logic [PRECISION-1:0] x1_init,
    input  logic [PRECISION-1:0] x2_init,
    output logic                 mul_req,
    output logic [PRECISION-1:0] mul_op_a,
    output logic [PRECISION-1:0] mul_op_b,
    input  logic                 mul_done,
    input  logic [PRECISION-1:0] mul_res,
    output logic                 add_req,
    output logic [PRECISION-1:0] add_op_a,
    output logic [PRECISION-1:0] add_op_b,
    input  logic                 add_done,
    input  logic [PRECISION-1:0] add_res,
    output logic [PRECISION-1:0] y0,
    output logic [PRECISION-1:0] y1,
    output logic [PRECISION-1:0] y2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_ADD, S_OUT} state_t;

    state_t               r_state;
    logic [PRECISION-1:0] r_a [0:8];
    logic [PRECISION-1:0] r_x [0:2];
    logic [PRECISION-1:0] r_y [0:2];
    logic [PRECISION-1:0] r_acc, r_p, r_mul_a, r_mul_b, r_add_a, r_add_b;
    logic [1:0]           r_i, r_j;
    logic                 r_acc_vld, r_mul_req, r_add_req, r_out_valid;

    logic [3:0]           w_idx;
    logic [PRECISION-1:0] w_coef, w_xj, w_acc_nxt;
    logic                 w_skip, w_mul_fire, w_add_fire, w_adv, w_vld_nxt;

    assign w_idx  = 4'(r_i) * 4'd3 + 4'(r_j);
    assign w_coef = r_a[w_idx];
    assign w_xj   = r_x[r_j];
`ifdef PRNG_ZERO_SKIP_EN
    assign w_skip = (w_coef[PRECISION-2:0] == '0);
`else
    assign w_skip = 1'b0;
`endif
    // done pulses only count while the matching request is outstanding
    assign w_mul_fire = (r_state == S_MUL) && r_mul_req && mul_done;
    assign w_add_fire = (r_state == S_ADD) && r_add_req && add_done;
    // a term completes on its first product, its accumulate, or a skipped coefficient
    assign w_adv      = (w_mul_fire && !r_acc_vld) || w_add_fire ||
                        ((r_state == S_MUL) && !r_mul_req && w_skip);
    assign w_acc_nxt  = w_add_fire ? add_res : w_mul_fire ? mul_res : r_acc;
    assign w_vld_nxt  = r_acc_vld || w_mul_fire || w_add_fire;

    assign mul_req   = r_mul_req;
    assign mul_op_a  = r_mul_a;
    assign mul_op_b  = r_mul_b;
    assign add_req   = r_add_req;
    assign add_op_a  = r_add_a;
    assign add_op_b  = r_add_b;
    assign y0        = r_y[0];
    assign y1        = r_y[1];
    assign y2        = r_y[2];
    assign out_valid = r_out_valid;
    assign busy      = (r_state != S_IDLE);

    // sequencer: latch operands, walk rows/cols through the shared units, hand off y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            for (int k = 0; k < 9; k++) r_a[k] <= '0;
            for (int k = 0; k < 3; k++) begin
                r_x[k] <= '0;
                r_y[k] <= '0;
            end
            r_acc       <= '0;
            r_p         <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_acc_vld   <= 1'b0;
            r_mul_req   <= 1'b0;
            r_add_req   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_a[0]    <= A00;
                    r_a[1]    <= A01;
                    r_a[2]    <= A02;
                    r_a[3]    <= A10;
                    r_a[4]    <= A11;
                    r_a[5]    <= A12;
                    r_a[6]    <= A20;
                    r_a[7]    <= A21;
                    r_a[8]    <= A22;
                    r_x[0]    <= x0_init;
                    r_x[1]    <= x1_init;
                    r_x[2]    <= x2_init;
                    r_i       <= '0;
                    r_j       <= '0;
                    r_acc_vld <= 1'b0;
                    r_state   <= S_MUL;
                end
                S_MUL: begin
                    if (!r_mul_req && !w_skip) begin
                        r_mul_req <= 1'b1;
                        r_mul_a   <= w_coef;
                        r_mul_b   <= w_xj;
                    end
                    if (w_mul_fire) begin
                        r_mul_req <= 1'b0;
                        r_p       <= mul_res;
                        if (r_acc_vld) r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    if (!r_add_req) begin
                        r_add_req <= 1'b1;
                        r_add_a   <= r_acc;
                        r_add_b   <= r_p;
                    end
                    if (w_add_fire) r_add_req <= 1'b0;
                end
                S_OUT: if (r_out_valid && out_ready) begin
                    for (int k = 0; k < 3; k++) r_x[k] <= r_y[k];
                    r_out_valid <= 1'b0;
                    r_i         <= '0;
                    r_j         <= '0;
                    r_acc_vld   <= 1'b0;
                    r_state     <= run ? S_MUL : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_adv) begin
                r_acc     <= w_acc_nxt;
                r_acc_vld <= w_vld_nxt;
                if (r_j != 2'd2) begin
                    r_j     <= r_j + 2'd1;
                    r_state <= S_MUL;
                end else begin
                    r_y[r_i]  <= w_vld_nxt ? w_acc_nxt : '0;
                    r_j       <= '0;
                    r_acc_vld <= 1'b0;
                    if (r_i != 2'd2) begin
                        r_i     <= r_i + 2'd1;
                        r_state <= S_MUL;
                    end else begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_prng_matvec_iter.sv
// tb_prng_matvec_iter: randomized bench with a behavioural FPU and a matrix-vector reference model.
module tb_prng_matvec_iter;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, run = 1'b0;
    logic [31:0] a_in [9];
    logic [31:0] x_in [3];
    logic        mul_req, add_req, out_valid, busy;
    logic [31:0] mul_op_a, mul_op_b, add_op_a, add_op_b, y0, y1, y2;
    logic        mul_done = 1'b0, add_done = 1'b0, out_ready = 1'b0;
    logic [31:0] mul_res = '0, add_res = '0;

    int checks = 0, passed = 0;
    int fpu_wait = 3;
    bit fpu_en = 1'b1;
    int mcnt = 0, acnt = 0, mul_reqs = 0, add_reqs = 0, unstable = 0;
    bit pm = 1'b0, pa = 1'b0;
    logic [31:0] mq_a[$], mq_b[$], aq_a[$], aq_b[$];

    logic [31:0] m_a [9];
    logic [31:0] m_x [3];
    logic [31:0] m_y [3];
    logic [31:0] ex_a[$], ex_b[$];
    int em, ea;

    prng_matvec_iter #(.PRECISION(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .run(run),
        .A00(a_in[0]), .A01(a_in[1]), .A02(a_in[2]),
        .A10(a_in[3]), .A11(a_in[4]), .A12(a_in[5]),
        .A20(a_in[6]), .A21(a_in[7]), .A22(a_in[8]),
        .x0_init(x_in[0]), .x1_init(x_in[1]), .x2_init(x_in[2]),
        .mul_req(mul_req), .mul_op_a(mul_op_a), .mul_op_b(mul_op_b),
        .mul_done(mul_done), .mul_res(mul_res),
        .add_req(add_req), .add_op_a(add_op_a), .add_op_b(add_op_b),
        .add_done(add_done), .add_res(add_res),
        .y0(y0), .y1(y1), .y2(y2),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic real f2r(logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) d = {f[31], 63'd0};
        else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(real r);
        logic [63:0] d;
        logic [24:0] m;
        int e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (d[62:52] == 11'd0 || e <= 0) return {d[63], 31'd0};
        m = {2'b01, d[51:29]};
        if (d[28] && (d[27:0] != 28'd0 || d[29])) m = m + 25'd1;
        if (m[24]) begin
            e++;
            m = m >> 1;
        end
        return {d[63], 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] fmul(logic [31:0] a, logic [31:0] b);
        return r2f(f2r(a) * f2r(b));
    endfunction

    function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] rnd_f();
        return {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
    endfunction

    // y = A*x, each row summed left to right; also the request counts and multiply pairs expected
    task automatic model_iter();
        logic [31:0] acc, p;
        bit have;
        em = 0;
        ea = 0;
        ex_a.delete();
        ex_b.delete();
        for (int i = 0; i < 3; i++) begin
            have = 1'b0;
            acc = '0;
            for (int j = 0; j < 3; j++) begin
`ifdef PRNG_ZERO_SKIP_EN
                if (m_a[i*3+j][30:0] == 31'd0) continue;
`endif
                p = fmul(m_a[i*3+j], m_x[j]);
                ex_a.push_back(m_a[i*3+j]);
                ex_b.push_back(m_x[j]);
                em++;
                if (have) begin
                    acc = fadd(acc, p);
                    ea++;
                end else acc = p;
                have = 1'b1;
            end
            m_y[i] = have ? acc : 32'd0;
        end
    endtask

    // behavioural FPU: done pulses fpu_wait cycles after a request is first seen
    initial forever begin
        @(negedge clk);
        if (mul_req && !pm) begin
            mul_reqs++;
            mq_a.push_back(mul_op_a);
            mq_b.push_back(mul_op_b);
        end else if (mul_req && (mul_op_a !== mq_a[$] || mul_op_b !== mq_b[$])) unstable++;
        if (add_req && !pa) begin
            add_reqs++;
            aq_a.push_back(add_op_a);
            aq_b.push_back(add_op_b);
        end else if (add_req && (add_op_a !== aq_a[$] || add_op_b !== aq_b[$])) unstable++;
        pm = mul_req;
        pa = add_req;
        if (!fpu_en) begin
            mcnt = 0;
            acnt = 0;
        end else begin
            if (mul_done) mul_done = 1'b0;
            else if (mul_req) begin
                if (mcnt >= fpu_wait) begin
                    mul_done = 1'b1;
                    mul_res = fmul(mul_op_a, mul_op_b);
                    mcnt = 0;
                end else mcnt++;
            end
            if (add_done) add_done = 1'b0;
            else if (add_req) begin
                if (acnt >= fpu_wait) begin
                    add_done = 1'b1;
                    add_res = fadd(add_op_a, add_op_b);
                    acnt = 0;
                end else acnt++;
            end
        end
    end

    task automatic clear_counts();
        mul_reqs = 0;
        add_reqs = 0;
        unstable = 0;
        mq_a.delete();
        mq_b.delete();
        aq_a.delete();
        aq_b.delete();
    endtask

    task automatic go();
        a_in = m_a;
        x_in = m_x;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                return;
            end
        end
        checks++;
        $display("FAIL out_valid_timeout: no out_valid within 3000 cycles");
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!busy) return;
        end
        checks++;
        $display("FAIL idle_timeout: busy still %b after 300 cycles", busy);
    endtask

    task automatic check_y(input string tag);
        checks++;
        if ({y0, y1, y2} !== {m_y[0], m_y[1], m_y[2]})
            $display("FAIL %s_y: got %h %h %h want %h %h %h", tag, y0, y1, y2, m_y[0], m_y[1], m_y[2]);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mul_req, add_req, out_valid, busy} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {mul_req, add_req, out_valid, busy});
        else passed++;
        checks++;
        if ({y0, y1, y2} !== 96'd0) $display("FAIL reset_y: got %h %h %h want 0", y0, y1, y2);
        else passed++;
        checks++;
        if ({mul_op_a, mul_op_b, add_op_a, add_op_b} !== 128'd0)
            $display("FAIL reset_ops: got %h %h %h %h want 0", mul_op_a, mul_op_b, add_op_a, add_op_b);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_identity();
        bit ok;
        int extra = 0;
        fpu_wait = 3;
        foreach (m_a[k]) m_a[k] = (k % 4 == 0) ? 32'h3F800000 : 32'h0;
        m_x = '{32'h3F800000, 32'h40000000, 32'h40400000};
        model_iter();
        run = 1'b0;
        out_ready = 1'b1;
        clear_counts();
        go();
        wait_out(ok);
        if (!ok) return;
        checks++;
        if ({y0, y1, y2} !== {32'h3F800000, 32'h40000000, 32'h40400000})
            $display("FAIL identity_y: got %h %h %h want 3f800000 40000000 40400000", y0, y1, y2);
        else passed++;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        checks++;
        if (extra != 0 || busy !== 1'b0) $display("FAIL identity_idle: extra valids %0d busy %b want 0 0", extra, busy);
        else passed++;
        checks++;
        if (mul_reqs != em || add_reqs != ea)
            $display("FAIL identity_counts: got mul %0d add %0d want %0d %0d", mul_reqs, add_reqs, em, ea);
        else passed++;
    endtask

    task automatic test_default_matrix();
        bit ok;
        logic [31:0] tgt [3];
        int d;
        fpu_wait = 2;
        m_a = '{32'h0, 32'h3F000000, 32'h3D4CCCCD, 32'h3EAAAAAB, 32'h0, 32'h3EAAAAAB,
                32'h3D4CCCCD, 32'h3F000000, 32'h0};
        m_x = '{32'h3DCCCCCD, 32'h3C23D70A, 32'h0};
        model_iter();
        tgt = '{r2f(0.005), r2f(1.0 / 30.0), r2f(0.01)};
        run = 1'b0;
        out_ready = 1'b1;
        clear_counts();
        go();
        wait_out(ok);
        if (!ok) return;
        check_y("default");
        for (int k = 0; k < 3; k++) begin
            d = int'(k == 0 ? y0 : k == 1 ? y1 : y2) - int'(tgt[k]);
            checks++;
            if (d > 1 || d < -1) $display("FAIL default_ulp%0d: off by %0d ulp from %h", k, d, tgt[k]);
            else passed++;
        end
        wait_idle();
`ifdef PRNG_ZERO_SKIP_EN
        checks++;
        if (mul_reqs != 6 || add_reqs != 3) $display("FAIL default_counts: got mul %0d add %0d want 6 3", mul_reqs, add_reqs);
        else passed++;
`else
        checks++;
        if (mul_reqs != 9 || add_reqs != 6) $display("FAIL default_counts: got mul %0d add %0d want 9 6", mul_reqs, add_reqs);
        else passed++;
`endif
        checks++;
        if (unstable != 0) $display("FAIL default_stable: %0d operand changes while req high, want 0", unstable);
        else passed++;
    endtask

    task automatic test_continuous();
        bit ok;
        logic [31:0] want [3] = '{32'h40000000, 32'h40800000, 32'h41000000};
        fpu_wait = 1;
        foreach (m_a[k]) m_a[k] = (k % 4 == 0) ? 32'h40000000 : 32'h0;
        m_x = '{32'h3F800000, 32'h0, 32'h0};
        model_iter();
        run = 1'b1;
        out_ready = 1'b1;
        go();
        for (int n = 0; n < 3; n++) begin
            wait_out(ok);
            if (!ok) return;
            checks++;
            if (y0 !== want[n]) $display("FAIL continuous_y0_%0d: got %h want %h", n, y0, want[n]);
            else passed++;
            check_y("continuous");
            if (n == 2) run = 1'b0;
            m_x = m_y;
            model_iter();
        end
        wait_idle();
    endtask

    task automatic test_backpressure();
        bit ok, stable;
        logic [31:0] h0, h1, h2;
        int snap;
        fpu_wait = 2;
        foreach (m_a[k]) m_a[k] = rnd_f();
        foreach (m_x[k]) m_x[k] = rnd_f();
        model_iter();
        run = 1'b1;
        out_ready = 1'b0;
        clear_counts();
        go();
        wait_out(ok);
        if (!ok) return;
        check_y("bp");
        {h0, h1, h2} = {y0, y1, y2};
        snap = mul_reqs;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!out_valid || {y0, y1, y2} !== {h0, h1, h2} || mul_req || add_req) stable = 1'b0;
        end
        checks++;
        if (!stable) $display("FAIL bp_hold: out_valid %b y %h req %b%b while stalled", out_valid, y0, mul_req, add_req);
        else passed++;
        checks++;
        if (mul_reqs != snap) $display("FAIL bp_no_issue: mul requests %0d want %0d", mul_reqs, snap);
        else passed++;
        out_ready = 1'b1;
        @(negedge clk);
        run = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) $display("FAIL bp_accept: out_valid %b busy %b want 0 1", out_valid, busy);
        else passed++;
        m_x = m_y;
        model_iter();
        wait_out(ok);
        if (!ok) return;
        check_y("bp_next");
        wait_idle();
    endtask

    task automatic test_reset_mid_add();
        bit ok, quiet;
        fpu_wait = 3;
        foreach (m_a[k]) m_a[k] = rnd_f();
        foreach (m_x[k]) m_x[k] = rnd_f();
        run = 1'b0;
        out_ready = 1'b1;
        clear_counts();
        go();
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            ok = (add_reqs == 3) && add_req;
        end
        checks++;
        if (!ok) begin
            $display("FAIL rst_reach_add: row1 add request not seen, got %0d adds", add_reqs);
            return;
        end
        passed++;
        fpu_en = 1'b0;
        mul_done = 1'b0;
        add_done = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mul_req, add_req, out_valid, busy} !== 4'b0000 || {y0, y1, y2} !== 96'd0)
            $display("FAIL rst_async: flags %b y %h %h %h want 0", {mul_req, add_req, out_valid, busy}, y0, y1, y2);
        else passed++;
        checks++;
        if ({mul_op_a, mul_op_b, add_op_a, add_op_b} !== 128'd0)
            $display("FAIL rst_async_ops: got %h %h %h %h want 0", mul_op_a, mul_op_b, add_op_a, add_op_b);
        else passed++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 add_done = 1'b1;
        add_res = $urandom;
        @(posedge clk);
        #1 add_done = 1'b0;
        quiet = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (mul_req || add_req || out_valid || busy) quiet = 1'b0;
        end
        checks++;
        if (!quiet) $display("FAIL rst_late_done: activity after stray add_done, busy %b", busy);
        else passed++;
        fpu_en = 1'b1;
        foreach (m_a[k]) m_a[k] = (k % 4 == 0) ? 32'h3F800000 : 32'h0;
        foreach (m_x[k]) m_x[k] = rnd_f();
        model_iter();
        go();
        wait_out(ok);
        if (!ok) return;
        checks++;
        if ({y0, y1, y2} !== {m_x[0], m_x[1], m_x[2]})
            $display("FAIL rst_restart: got %h %h %h want %h %h %h", y0, y1, y2, m_x[0], m_x[1], m_x[2]);
        else passed++;
        wait_idle();
    endtask

    task automatic test_zero_latency();
        bit ok, same;
        fpu_wait = 0;
        foreach (m_a[k]) m_a[k] = (k % 4 == 0) ? 32'h3F800000 : 32'h0;
        foreach (m_x[k]) m_x[k] = rnd_f();
        model_iter();
        run = 1'b0;
        out_ready = 1'b1;
        clear_counts();
        go();
        wait_out(ok);
        if (!ok) return;
        checks++;
        if ({y0, y1, y2} !== {m_x[0], m_x[1], m_x[2]})
            $display("FAIL zl_identity: got %h %h %h want %h %h %h", y0, y1, y2, m_x[0], m_x[1], m_x[2]);
        else passed++;
        same = (mq_a.size() == ex_a.size());
        if (same) foreach (ex_a[k]) if (mq_a[k] !== ex_a[k] || mq_b[k] !== ex_b[k]) same = 1'b0;
        checks++;
        if (!same) $display("FAIL zl_pairs: got %0d mul pairs want %0d in row-major order", mq_a.size(), ex_a.size());
        else passed++;
        checks++;
        if (add_reqs != ea || unstable != 0) $display("FAIL zl_adds: got %0d adds %0d unstable want %0d 0", add_reqs, unstable, ea);
        else passed++;
        wait_idle();
    endtask

    task automatic test_random();
        bit ok;
        for (int r = 0; r < 4; r++) begin
            fpu_wait = $urandom_range(0, 4);
            foreach (m_a[k]) m_a[k] = ($urandom_range(0, 3) == 0) ? {1'($urandom), 31'd0} : rnd_f();
            foreach (m_x[k]) m_x[k] = rnd_f();
            model_iter();
            run = 1'b1;
            out_ready = 1'b0;
            go();
            foreach (a_in[k]) a_in[k] = $urandom;
            foreach (x_in[k]) x_in[k] = $urandom;
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk) start = 1'b0;
            for (int n = 0; n < 3; n++) begin
                wait_out(ok);
                if (!ok) return;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                check_y("random");
                run = (n < 2);
                out_ready = 1'b1;
                @(negedge clk) out_ready = 1'b0;
                m_x = m_y;
                model_iter();
            end
            wait_idle();
        end
    endtask

    initial begin
        foreach (a_in[k]) a_in[k] = '0;
        foreach (x_in[k]) x_in[k] = '0;
        test_reset();
        test_identity();
        test_default_matrix();
        test_continuous();
        test_backpressure();
        test_reset_mid_add();
        test_zero_latency();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
